// File: rtl/demux_4out_nbit_reg.sv
// Registered 1-to-4 N-bit demultiplexer with a one-deep valid/ready holding register per channel.
// Optional macro DEMUX_BCAST_EN adds a bcast input that loads all four channels at once.
module demux_4out_nbit_reg #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] din,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         s1,
  input  logic         s0,
`ifdef DEMUX_BCAST_EN
  input  logic         bcast,
`endif
  output logic [N-1:0] A,
  output logic [N-1:0] B,
  output logic [N-1:0] C,
  output logic [N-1:0] D,
  output logic         a_valid,
  output logic         b_valid,
  output logic         c_valid,
  output logic         d_valid,
  input  logic         a_ready,
  input  logic         b_ready,
  input  logic         c_ready,
  input  logic         d_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} ch_state_t;

  logic [1:0]   sel_idx;
  logic [3:0]   sel_hot;
  logic [3:0]   hit;
  logic [3:0]   ready_vec;
  logic [3:0]   valid_vec;
  logic [3:0]   pop;
  logic [3:0]   free;
  logic [3:0]   load;
  logic         accept;
  logic [N-1:0] data_out [4];

  assign sel_idx   = {s1, s0};
  assign ready_vec = {d_ready, c_ready, b_ready, a_ready};
  assign pop       = valid_vec & ready_vec;
  // A channel can take a word if it is empty or is handing its word off this cycle.
  assign free      = ~valid_vec | pop;

  always_comb begin
    sel_hot          = 4'b0000;
    sel_hot[sel_idx] = 1'b1;
  end

`ifdef DEMUX_BCAST_EN
  assign hit      = bcast ? 4'b1111 : sel_hot;
  assign in_ready = !rst && (bcast ? (&free) : free[sel_idx]);
`else
  assign hit      = sel_hot;
  assign in_ready = !rst && free[sel_idx];
`endif

  assign accept = in_valid && in_ready;
  assign load   = accept ? hit : 4'b0000;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
      ch_state_t    state_reg;
      ch_state_t    state_next;
      logic [N-1:0] data_reg;

      always_comb begin
        state_next = state_reg;
        case (state_reg)
          EMPTY:   if (load[gi]) state_next = FULL;
          FULL:    if (pop[gi] && !load[gi]) state_next = EMPTY;
          default: state_next = EMPTY;
        endcase
      end

      // Data is only overwritten on load; after a pop it keeps the last word.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= EMPTY;
          data_reg  <= '0;
        end else begin
          state_reg <= state_next;
          if (load[gi]) data_reg <= din;
        end
      end

      assign valid_vec[gi] = (state_reg == FULL);
      assign data_out[gi]  = data_reg;
    end
  endgenerate

  assign A       = data_out[0];
  assign B       = data_out[1];
  assign C       = data_out[2];
  assign D       = data_out[3];
  assign a_valid = valid_vec[0];
  assign b_valid = valid_vec[1];
  assign c_valid = valid_vec[2];
  assign d_valid = valid_vec[3];

endmodule

// File: tb/tb_demux_4out_nbit_reg.sv
// Randomized and directed bench for demux_4out_nbit_reg against a per-channel behavioural model.
module tb_demux_4out_nbit_reg;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] din;
  logic         in_valid;
  logic         in_ready;
  logic         s1, s0;
  logic         bcast;
  logic [N-1:0] A, B, C, D;
  logic         a_valid, b_valid, c_valid, d_valid;
  logic         a_ready, b_ready, c_ready, d_ready;

  int n_checks = 0;
  int n_fail   = 0;

  bit [N-1:0] exp_data  [4];
  bit         exp_valid [4];

  always #5 clk = ~clk;

  demux_4out_nbit_reg #(.N(N)) dut (
    .clk(clk), .rst(rst), .din(din), .in_valid(in_valid), .in_ready(in_ready),
    .s1(s1), .s0(s0),
`ifdef DEMUX_BCAST_EN
    .bcast(bcast),
`endif
    .A(A), .B(B), .C(C), .D(D),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit rdy_of(input int ch);
    case (ch)
      0: return a_ready;
      1: return b_ready;
      2: return c_ready;
      default: return d_ready;
    endcase
  endfunction

  // One cycle: check in_ready against the model, advance the model at the edge, then check outputs.
  task automatic step(input string tag);
    bit free [4];
    bit exp_rdy, all_free, use_bcast, acc;
    int sel;
    #1;
    sel = {s1, s0};
`ifdef DEMUX_BCAST_EN
    use_bcast = bcast;
`else
    use_bcast = 1'b0;
`endif
    all_free = 1'b1;
    for (int ch = 0; ch < 4; ch++) begin
      free[ch] = !exp_valid[ch] || rdy_of(ch);
      all_free = all_free && free[ch];
    end
    exp_rdy = !rst && (use_bcast ? all_free : free[sel]);
    check({tag, ".in_ready"}, in_ready, exp_rdy);
    acc = in_valid && exp_rdy;
    for (int ch = 0; ch < 4; ch++) begin
      if (rst) begin
        exp_valid[ch] = 1'b0;
        exp_data[ch]  = '0;
      end else if (acc && (use_bcast || ch == sel)) begin
        exp_valid[ch] = 1'b1;
        exp_data[ch]  = din;
      end else if (exp_valid[ch] && rdy_of(ch)) begin
        exp_valid[ch] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check({tag, ".A"}, A, exp_data[0]);
    check({tag, ".B"}, B, exp_data[1]);
    check({tag, ".C"}, C, exp_data[2]);
    check({tag, ".D"}, D, exp_data[3]);
    check({tag, ".valid"}, {d_valid, c_valid, b_valid, a_valid},
          {exp_valid[3], exp_valid[2], exp_valid[1], exp_valid[0]});
    $display("%s: din=%02h sel=%0d in_valid=%0b in_ready=%0b A=%02h B=%02h C=%02h D=%02h v=%b%b%b%b",
             tag, din, sel, in_valid, exp_rdy, A, B, C, D, d_valid, c_valid, b_valid, a_valid);
  endtask

  task automatic send(input string tag, input logic [N-1:0] d, input int sel);
    in_valid = 1'b1;
    din      = d;
    {s1, s0} = sel[1:0];
    step(tag);
  endtask

  task automatic set_ready(input logic [3:0] r);
    {d_ready, c_ready, b_ready, a_ready} = r;
  endtask

  initial begin
    rst = 1'b1; din = '0; in_valid = 1'b0; s1 = 1'b0; s0 = 1'b0; bcast = 1'b0;
    set_ready(4'b0000);
    for (int ch = 0; ch < 4; ch++) begin
      exp_valid[ch] = 1'b0;
      exp_data[ch]  = '0;
    end

    // Reset, then route one word to each channel
    step("reset0");
    step("reset1");
    rst = 1'b0;
    set_ready(4'b1111);
    for (int i = 0; i < 4; i++) send("route", 8'(i + 1), i);
    in_valid = 1'b0;
    step("route_drain");
    check("route.A_final", A, 8'd1);
    check("route.D_final", D, 8'd4);

    // Backpressure on A, with an independent write to C while A is stalled
    set_ready(4'b1110);
    send("bp_a80", 8'h80, 0);
    send("bp_a40_stall", 8'h40, 0);
    check("bp.A_hold", A, 8'h80);
    send("indep_c20", 8'h20, 2);
    check("indep.C", C, 8'h20);
    check("indep.A", A, 8'h80);
    set_ready(4'b1111);
    send("bp_a40_go", 8'h40, 0);
    check("bp.A_new", A, 8'h40);
    in_valid = 1'b0;
    step("bp_drain");

    // Reset mid-operation with B and D full
    set_ready(4'b0000);
    send("mid_b", 8'h55, 1);
    send("mid_d", 8'h66, 3);
    rst = 1'b1;
    send("mid_rst", 8'h77, 0);
    rst = 1'b0;
    send("mid_d10", 8'h10, 3);
    check("mid.D", D, 8'h10);

    // Back-to-back writes to D while its consumer drains every cycle
    set_ready(4'b1111);
    step("b2b_pop");
    for (int i = 1; i <= 8; i++) send("b2b", 8'(i), 3);
    check("b2b.D_last", D, 8'h08);
    in_valid = 1'b0;
    step("b2b_drain");

`ifdef DEMUX_BCAST_EN
    set_ready(4'b1101);
    send("bc_b", 8'h33, 1);
    bcast = 1'b1;
    send("bc_stall", 8'hAA, 0);
    set_ready(4'b1111);
    send("bc_go", 8'hAA, 0);
    check("bc.all", {A, B, C, D}, {4{8'hAA}});
    bcast = 1'b0;
    in_valid = 1'b0;
    step("bc_drain");
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rst      = ($urandom_range(49) == 0);
      in_valid = $urandom_range(3) != 0;
      din      = N'($urandom);
      {s1, s0} = 2'($urandom);
`ifdef DEMUX_BCAST_EN
      bcast    = ($urandom_range(7) == 0);
`endif
      set_ready(4'($urandom));
      step("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
